font_pixel_reader: RTL

- Reads the character font ROM and turns its 8-bit glyph rows into a serial pixel stream for the VGA text layer of the RTC display.
- Drives the ROM address and character-set select, captures row data one clock later, and shifts it out MSB-first.
- Each bit is one pixel of an 8x16 cell, timed by the VGA sync generator's pixel tick.
- Sits between the text-map logic (which supplies the character code per cell) and the RGB output mux.

---
 rtl/font_pixel_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/font_pixel_reader.sv
// Font ROM row fetcher and MSB-first pixel serialiser for the VGA text layer.
// A row is fetched at column 6 of each cell and loaded into the shifter at column 7.
module font_pixel_reader #(
  parameter int unsigned H_TOTAL  = 800,
  parameter logic [7:0]  FG_COLOR = 8'hFF,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_tick_i,
  input  logic       video_on_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  input  logic       char_valid_i,
  input  logic [3:0] char_sel_i,
  input  logic [1:0] char_slot_i,
  output logic [1:0] rom_ad_o,
  output logic [3:0] rom_lsby_o,
  output logic [3:0] rom_sel_o,
  input  logic [7:0] rom_data_i,
  output logic [7:0] rgb_o,
  output logic       pix_on_o,
  output logic       underrun_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAddr  = 2'd1;
  localparam logic [1:0] StCapt  = 2'd2;
  localparam logic [1:0] StReady = 2'd3;

  localparam logic [9:0] LastCellX = 10'(H_TOTAL - 8);

  logic [1:0] state_q, state_d;
  logic [1:0] rom_ad_q, rom_ad_d;
  logic [3:0] rom_lsby_q, rom_lsby_d;
  logic [3:0] rom_sel_q, rom_sel_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rgb_q, rgb_d;
  logic       pix_on_q, pix_on_d;
  logic       under_q, under_d;

  logic       fetch;
  logic       load;
  logic       sel_ok;
  logic [3:0] fetch_row;

  always_comb begin
    fetch  = pix_tick_i && (pixel_x_i[2:0] == 3'b110) && (state_q == StIdle);
    load   = pix_tick_i && (pixel_x_i[2:0] == 3'b111);
    sel_ok = char_valid_i && (char_sel_i != 4'd0) && (char_sel_i <= 4'd6);
    // The last cell of a line prefetches the row of the following line.
    fetch_row = pixel_y_i[3:0] + {3'b000, (pixel_x_i >= LastCellX)};
  end

  always_comb begin
    state_d    = state_q;
    rom_ad_d   = rom_ad_q;
    rom_lsby_d = rom_lsby_q;
    rom_sel_d  = rom_sel_q;
    pre_d      = pre_q;

    case (state_q)
      StIdle: begin
        if (fetch) begin
          state_d    = StAddr;
          rom_ad_d   = char_slot_i;
          rom_lsby_d = fetch_row;
          rom_sel_d  = sel_ok ? char_sel_i : 4'd0;
        end
      end
      StAddr:  state_d = StCapt;
      StCapt: begin
        state_d = StReady;
        pre_d   = (rom_sel_q == 4'd0) ? 8'h00 : rom_data_i;
      end
      default: state_d = StReady;
    endcase

    // A load always ends the fetch; an unfinished one is dropped so it cannot
    // leak stale data into the next cell.
    if (load) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    sh_d     = sh_q;
    rgb_d    = rgb_q;
    pix_on_d = pix_on_q;
    under_d  = under_q;
    if (pix_tick_i) begin
      rgb_d    = video_on_i ? (sh_q[7] ? FG_COLOR : BG_COLOR) : 8'h00;
      pix_on_d = video_on_i & sh_q[7];
      if (load) begin
        if (state_q == StReady) begin
          sh_d = pre_q;
        end else begin
          sh_d    = 8'h00;
          under_d = 1'b1;
        end
      end else begin
        sh_d = {sh_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rom_ad_q   <= 2'd0;
      rom_lsby_q <= 4'd0;
      rom_sel_q  <= 4'd0;
      pre_q      <= 8'h00;
      sh_q       <= 8'h00;
      rgb_q      <= 8'h00;
      pix_on_q   <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_ad_q   <= rom_ad_d;
      rom_lsby_q <= rom_lsby_d;
      rom_sel_q  <= rom_sel_d;
      pre_q      <= pre_d;
      sh_q       <= sh_d;
      rgb_q      <= rgb_d;
      pix_on_q   <= pix_on_d;
      under_q    <= under_d;
    end
  end

  assign rom_ad_o   = rom_ad_q;
  assign rom_lsby_o = rom_lsby_q;
  assign rom_sel_o  = rom_sel_q;
  assign rgb_o      = rgb_q;
  assign pix_on_o   = pix_on_q;
  assign underrun_o = under_q;

endmodule
